// File: rtl/huc_pkg.sv
// Shared HuCard bus types for the cart-side mapper blocks.
// CPU bus, memory-controller bundle and mapper constants.
package huc_pkg;

  localparam int ROM_AW       = 24;
  localparam int HUC_WIN_BITS = 19;
  localparam logic [20:0] HUC_REG_BASE = 21'h01FF0;

  typedef struct packed {
    logic [20:0] addr;
    logic [7:0]  data;
    logic        ce;
    logic        oe;
    logic        we;
  } CpuBus;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [7:0]        dati;
    logic              ce;
    logic              ce2;
    logic              oe;
    logic              we;
  } MemCtrl;

  typedef struct packed {
    CpuBus      cpu;
    logic [7:0] rom_dato;
    logic [7:0] ram_dato;
  } HucIn;

  typedef struct packed {
    MemCtrl     rom;
    MemCtrl     ram;
    logic       cart_ce;
    logic [7:0] cart_dato;
    logic       led;
  } HucOut;

endpackage

// File: rtl/huc_bank.sv
// HuCard mapper: fixed low 512 KB, bank-switched upper window,
// optional cart RAM and a bank-activity LED.
module huc_bank
  import huc_pkg::*;
#(
  parameter int          BANK_BITS = 2,
  parameter logic [20:0] REG_BASE  = HUC_REG_BASE,
  parameter bit          RAM_EN    = 1'b0,
  parameter logic [5:0]  RAM_PAGE  = 6'h10,
  parameter logic [23:0] LED_HOLD  = 24'd4_000_000,
  parameter int          HB_BIT    = 24
) (
  input  logic clk,
  input  logic rst,
  input  HucIn huc_i,
  output HucOut huc_o,
  output logic [(BANK_BITS>0?BANK_BITS:1)-1:0] bank_o
);

  localparam int BW = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int PW = ROM_AW - HUC_WIN_BITS;

  CpuBus cpu;
  logic ram_hit, rom_hit, reg_hit;
  logic wr_req, upd;
  logic [PW-1:0] page;
  logic [ROM_AW-1:0] rom_addr;

  logic [BW-1:0] bank_q, bank_d;
  logic          wr_q, wr_d;
  logic [23:0]   hold_q, hold_d;
  logic [24:0]   hb_q, hb_d;

  assign cpu = huc_i.cpu;

  always_comb begin
    ram_hit = RAM_EN && (cpu.addr[20:15] == RAM_PAGE);
    rom_hit = ~ram_hit & ~cpu.addr[20];
    reg_hit = cpu.addr[20:BANK_BITS] == REG_BASE[20:BANK_BITS];
    // RAM-window writes never double as bank strobes
    wr_req = cpu.ce & cpu.we & reg_hit & ~ram_hit;
    upd = wr_req & ~wr_q & (BANK_BITS > 0);

    page = PW'(bank_q) + PW'(1);
    rom_addr = {{PW{1'b0}}, cpu.addr[18:0]};
    if (BANK_BITS == 0)
      rom_addr = ROM_AW'(cpu.addr[19:0]);
    else if (cpu.addr[19])
      rom_addr = {page, cpu.addr[18:0]};
  end

  always_comb begin
    bank_d = bank_q;
    wr_d = wr_req;
    hb_d = hb_q + 25'd1;
    hold_d = (hold_q != '0) ? hold_q - 24'd1 : '0;
    if (upd) begin
      bank_d = cpu.addr[BW-1:0];
      hold_d = LED_HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
      wr_q   <= 1'b0;
      hold_q <= '0;
      hb_q   <= '0;
    end else begin
      bank_q <= bank_d;
      wr_q   <= wr_d;
      hold_q <= hold_d;
      hb_q   <= hb_d;
    end
  end

  always_comb begin
    huc_o = '0;
    huc_o.rom.addr = rom_addr;
    huc_o.rom.dati = cpu.data;
    huc_o.rom.ce   = rom_hit;
    huc_o.rom.ce2  = cpu.ce;
    huc_o.rom.oe   = cpu.oe;
    huc_o.rom.we   = 1'b0;
    if (RAM_EN) begin
      huc_o.ram.addr = ROM_AW'(cpu.addr[14:0]);
      huc_o.ram.dati = cpu.data;
      huc_o.ram.ce   = ram_hit;
      huc_o.ram.ce2  = cpu.ce;
      huc_o.ram.oe   = cpu.oe;
      huc_o.ram.we   = ram_hit & cpu.we;
    end
    huc_o.cart_ce = huc_o.rom.ce | huc_o.ram.ce;
    huc_o.cart_dato = huc_o.ram.ce ? huc_i.ram_dato
                                   : huc_i.rom_dato;
    huc_o.led = (hold_q != '0) ? 1'b1 : hb_q[HB_BIT];
  end

  assign bank_o = bank_q;

endmodule
